counter_0_9_up: RTL
===================

// Module: counter_0_9_up
// PURPOSE
//  Cascadable BCD up-counter: the count-up counterpart of the 9->0 down counter.
//  Used for elapsed-time (stopwatch) digits, counting 0 -> MAX_COUNT in packed BCD.
//  Flags end_condition at MAX_COUNT, then either holds or wraps to 0.
//  Each digit is a 0..9 stage; carries ripple between digits in the same clock cycle.
// PARAMETERS
//  DIGITS     2      number of BCD digits; count width = 4*DIGITS
//  MAX_COUNT  8'h59  terminal value, packed BCD; every nibble <= 9; must be nonzero
//  WRAP       0      0: hold at MAX_COUNT; 1: next step goes to 0 and pulses carry
// PORTS
//  clock_in      in   1         single clock; all state changes on its rising edge
//  reset         in   1         asynchronous, active-low reset
//  enable        in   1         count one step on this edge
//  clear         in   1         synchronous clear to 0
//  load          in   1         synchronous load of load_value
//  load_value    in   4*DIGITS  packed BCD value to load
//  count         out  4*DIGITS  current value, packed BCD, LS digit in [3:0]
//  end_condition out  1         high while count == MAX_COUNT
//  carry         out  1         registered one-cycle pulse after a wrap (WRAP=1 only)
// BEHAVIOUR
//  - Reset (reset==0, async): count=0, carry=0, end_condition=0. All are released synchronously.
//  - Per-edge priority: clear > load > enable > hold.
//  - enable: digit i increments when all digits below i are 9. A digit at 9 rolls over to 0.
//    Result appears on count at the same edge (latency 1 edge from enable sampled).
//  - end_condition: combinational compare of registered count against MAX_COUNT.
//  - At MAX_COUNT with enable=1:
//    - WRAP=0: count holds and end_condition stays 1 (counting stops).
//    - WRAP=1: count becomes 0 on that edge, and carry=1 for exactly the next cycle.
//  - carry is 0 in every other cycle. clear or load never produce carry.
//  - load sanitising:
//    - Any nibble > 9 is loaded as 0.
//    - If the sanitised value > MAX_COUNT (BCD compare), MAX_COUNT is loaded.
//  - clear and load in the same edge: clear wins, count=0.
//  - enable=0: count holds, including at MAX_COUNT. The state never leaves legal BCD.
//  - reset asserted mid-count: count drops to 0 immediately, without waiting for a clock edge.
//    Any pending carry is cancelled.
// STRUCTURE
//  - Shared package (counters_pkg):
//    - BCD_DIGIT_MAX = 4'd9.
//    - Function bcd_sanitise(nibble).
//    - Function bcd_gt(a, b) for packed-BCD compare.
//    - These are reused by the down counters.
//  - Sub-module bcd_digit_up: one digit; instantiated DIGITS times.
//    - Inputs: clock_in, reset, inc, clear, load, d[3:0].
//    - Outputs: q[3:0], is_nine.
//    - inc chain: inc[0]=enable & ~at_max_hold; inc[i]=inc[i-1] & is_nine[i-1].
//  - Top level holds the MAX compare, the wrap/hold decision and the carry register.
//  - No gated clocks: enable is a synchronous qualifier, not ANDed into clock_in.
// TESTING
//  1 reset=0 for 2 cycles, then release -> count=8'h00, end_condition=0, carry=0.
//  2 enable=1 for 59 edges from 0 -> count=8'h59, end_condition=1. 5 more enables -> still 8'h59.
//  3 WRAP=1, count 8'h59, one enable -> count=8'h00 and carry=1 for exactly one cycle, then 0.
//  4 load 8'h47, then 3 enables -> 8'h48, 8'h49, 8'h50 (digit rollover carries into tens).
//  5 load 8'h5C -> 8'h50. load 8'h73 -> 8'h59, end_condition=1. clear+load same edge -> 8'h00.
//  6 count 8'h35, reset pulsed low between edges -> count=8'h00 before the next edge.
//    The next enable -> 8'h01.

Source files
------------

// File: rtl/counters_pkg.sv
// Shared BCD helpers for the stopwatch up/down counter family.
package counters_pkg;

  localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;
  localparam int unsigned BCD_CMP_W     = 32;

  // Illegal nibbles (A-F) collapse to zero.
  function automatic logic [3:0] bcd_sanitise(input logic [3:0] nibble);
    return (nibble > BCD_DIGIT_MAX) ? 4'd0 : nibble;
  endfunction

  // For legal packed BCD, numeric order matches binary order of the packed word.
  function automatic logic bcd_gt(input logic [BCD_CMP_W-1:0] a,
                                  input logic [BCD_CMP_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/counter_0_9_up_digit.sv
// One 0..9 BCD stage with clear > load > inc priority.
module bcd_digit_up
  import counters_pkg::*;
(
  input  logic       clock_in,
  input  logic       reset,
  input  logic       inc,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       is_nine
);

  assign is_nine = (q == BCD_DIGIT_MAX);

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      q <= 4'd0;
    end else if (clear) begin
      q <= 4'd0;
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= is_nine ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/counter_0_9_up.sv
// Cascadable packed-BCD up counter 0..MAX_COUNT with hold or wrap at the terminal value.
module counter_0_9_up
  import counters_pkg::*;
#(
  parameter int unsigned           DIGITS    = 2,
  parameter logic [4*DIGITS-1:0]   MAX_COUNT = 8'h59,
  parameter bit                    WRAP      = 1'b0
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  end_condition,
  output logic                  carry
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]      load_san;
  logic [W-1:0]      load_fixed;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] is_nine;
  logic              at_max;
  logic              at_max_hold;
  logic              wrap_now;
  logic              digit_clear;

  assign at_max        = (count == MAX_COUNT);
  assign end_condition = at_max;
  // Digits never step past MAX; a wrap is done by clearing all digits instead.
  assign at_max_hold   = at_max;
  assign wrap_now      = WRAP && enable && at_max && !clear && !load;
  assign digit_clear   = clear | wrap_now;

  always_comb begin
    load_san = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_san[4*i +: 4] = bcd_sanitise(load_value[4*i +: 4]);
    end
  end

  assign load_fixed = bcd_gt(BCD_CMP_W'(load_san), BCD_CMP_W'(MAX_COUNT)) ? MAX_COUNT
                                                                           : load_san;

  assign inc[0] = enable & ~at_max_hold;

  genvar g;
  generate
    for (g = 1; g < int'(DIGITS); g++) begin : g_chain
      assign inc[g] = inc[g-1] & is_nine[g-1];
    end

    for (g = 0; g < int'(DIGITS); g++) begin : g_digit
      bcd_digit_up u_digit (
        .clock_in (clock_in),
        .reset    (reset),
        .inc      (inc[g]),
        .clear    (digit_clear),
        .load     (load),
        .d        (load_fixed[4*g +: 4]),
        .q        (count[4*g +: 4]),
        .is_nine  (is_nine[g])
      );
    end
  endgenerate

  // One-cycle pulse following the wrap edge.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
    end else begin
      carry <= wrap_now;
    end
  end

endmodule
